alu_fib_ctrl: RTL and testbench
===============================

// Module: alu_fib_ctrl
// PURPOSE
//   Sequencer placed directly upstream of the ALU. It drives the ALU's OP/A/B inputs and
//   captures F/CF from the ALU's outputs to generate a Fibonacci-style sequence:
//   t(k) = t(k-2) + t(k-1), seeded by f0/f1.
//   Each new term is streamed out over a valid/ready handshake. The block gives the ALU
//   its register-and-control context; the ALU itself stays purely combinational.
// PARAMETERS
//   SIZE   5  data MSB index; every data path is SIZE+1 bits wide (matches ALU SIZE)
//   CNT_W  4  width of the term-count input n and the internal down-counter
// PORTS
//   clk       in   1        clock, rising edge
//   rst_n     in   1        asynchronous reset, active-low
//   start     in   1        begin a sequence; sampled only in IDLE
//   f0        in   SIZE+1   seed t(0); latched when start is accepted
//   f1        in   SIZE+1   seed t(1); latched when start is accepted
//   n         in   CNT_W    number of new terms to emit (0 = emit none)
//   alu_op    out  3        ALU operation; 3'b100 (add) in CALC, 3'b000 otherwise
//   alu_a     out  SIZE+1   ALU left operand = a_reg
//   alu_b     out  SIZE+1   ALU right operand = b_reg
//   alu_f     in   SIZE+1   ALU result (combinational, same cycle)
//   alu_cf    in   1        ALU carry flag
//   out_valid out  1        out_data holds a new term
//   out_ready in   1        consumer accepts out_data this cycle
//   out_data  out  SIZE+1   emitted term (truncated to SIZE+1 bits on carry)
//   busy      out  1        high in every state except IDLE
//   done      out  1        one-cycle pulse in DONE
//   ovf       out  1        sticky: carry seen in this sequence; cleared on start accept
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE; a_reg, b_reg, cnt, out_data, out_valid, done, ovf all 0.
//     - Outputs go to these values immediately, even mid-sequence.
//   States: IDLE, CALC, WAIT, DONE (registered; outputs are decoded from registers only).
//   IDLE: busy=0. start=1 -> a_reg<=f0, b_reg<=f1, cnt<=n, ovf<=0;
//     next state is CALC if n!=0, else DONE.
//   CALC (exactly 1 cycle):
//     - alu_op=3'b100.
//     - out_data<=alu_f, out_valid<=1, a_reg<=b_reg, b_reg<=alu_f, cnt<=cnt-1.
//     - If alu_cf=1, ovf<=1.
//     - Next state: WAIT.
//   WAIT:
//     - out_valid and out_data are held stable; the ALU operands do not advance.
//     - On out_valid & out_ready: out_valid<=0. Next state is DONE if cnt==0 or ovf==1,
//       else CALC.
//   DONE: done=1 for one cycle -> IDLE. ovf holds until the next accepted start.
//   Latency:
//     - start accepted at edge k -> CALC in cycle k+1 -> first out_valid in cycle k+2.
//     - With out_ready held high, successive terms arrive every 2 cycles.
//   Arithmetic: unsigned, modulo 2^(SIZE+1); carry ends the sequence after the carrying
//     term is delivered (that term is still emitted, truncated).
//   start outside IDLE is ignored. n is latched, so later changes to n have no effect.
// TESTING
//   T1: f0=1, f1=1, n=5, out_ready=1 -> out_data 2,3,5,8,13; then done pulse; ovf=0;
//       busy falls after DONE.
//   T2: n=0, start -> no out_valid; done high exactly in the cycle after accept;
//       back to IDLE.
//   T3: SIZE=5, f0=21, f1=34, n=3 -> terms 55, then 25 (89 mod 64) with ovf=1;
//       only 2 terms emitted, then done.
//   T4: f0=1, f1=2, n=3 with out_ready low for 3 cycles on the first term ->
//       out_data=3 is held stable; a_reg/b_reg unchanged; sequence then continues 5, 8.
//   T5: rst_n pulsed low during WAIT -> all outputs 0 asynchronously;
//       a new start after release runs cleanly.
//   T6: start pulsed while busy -> ignored; the current sequence output is unchanged.

Source files
------------

// File: rtl/alu_fib_ctrl.sv
// Fibonacci-style sequencer wrapped around a combinational ALU: drives OP/A/B,
// captures F/CF and streams each new term over a valid/ready handshake.
module alu_fib_ctrl #(
   parameter int unsigned SIZE  = 5,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [SIZE:0]    f0_i,
   input  logic [SIZE:0]    f1_i,
   input  logic [CNT_W-1:0] n_i,
   output logic [2:0]       alu_op_o,
   output logic [SIZE:0]    alu_a_o,
   output logic [SIZE:0]    alu_b_o,
   input  logic [SIZE:0]    alu_f_i,
   input  logic             alu_cf_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [SIZE:0]    out_data_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             ovf_o
);

   typedef enum logic [1:0] {StIdle, StCalc, StWait, StDone} state_e;

   state_e             state_q, state_d;
   logic [SIZE:0]      a_q, a_d, b_q, b_d, data_q, data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               valid_q, valid_d, ovf_q, ovf_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               a_d     = f0_i;
               b_d     = f1_i;
               cnt_d   = n_i;
               ovf_d   = 1'b0;
               state_d = (n_i != '0) ? StCalc : StDone;
            end
         end
         StCalc: begin
            data_d  = alu_f_i;
            valid_d = 1'b1;
            a_d     = b_q;
            b_d     = alu_f_i;
            cnt_d   = cnt_q - 1'b1;
            if (alu_cf_i) ovf_d = 1'b1;
            state_d = StWait;
         end
         StWait: begin
            // A carry ends the sequence once the truncated term has been taken.
            if (valid_q && out_ready_i) begin
               valid_d = 1'b0;
               state_d = (cnt_q == '0 || ovf_q) ? StDone : StCalc;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign alu_op_o    = (state_q == StCalc) ? 3'b100 : 3'b000;
   assign alu_a_o     = a_q;
   assign alu_b_o     = b_q;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;
   assign busy_o      = (state_q != StIdle);
   assign done_o      = (state_q == StDone);
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_alu_fib_ctrl.sv
// Bench for alu_fib_ctrl: behavioural ALU plus a term-list reference model,
// directed cases followed by randomized sequences with random back-pressure.
module tb_alu_fib_ctrl;
   localparam int unsigned SIZE  = 5;
   localparam int unsigned CNT_W = 4;
   localparam int          Mod   = 1 << (SIZE + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [SIZE:0]    f0 = '0, f1 = '0;
   logic [CNT_W-1:0] n = '0;
   logic [2:0]       alu_op;
   logic [SIZE:0]    alu_a, alu_b, alu_f;
   logic             alu_cf;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [SIZE:0]    out_data;
   logic             busy, done, ovf;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   // Behavioural ALU: add for 3'b100, zero otherwise.
   assign {alu_cf, alu_f} = (alu_op == 3'b100) ? ({1'b0, alu_a} + {1'b0, alu_b}) : '0;

   alu_fib_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .f0_i        (f0),
      .f1_i        (f1),
      .n_i         (n),
      .alu_op_o    (alu_op),
      .alu_a_o     (alu_a),
      .alu_b_o     (alu_b),
      .alu_f_i     (alu_f),
      .alu_cf_i    (alu_cf),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .busy_o      (busy),
      .done_o      (done),
      .ovf_o       (ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 0);
      chk({tag, "_data"},  32'(out_data),  0);
      chk({tag, "_busy"},  32'(busy),      0);
      chk({tag, "_done"},  32'(done),      0);
      chk({tag, "_ovf"},   32'(ovf),       0);
      chk({tag, "_a"},     32'(alu_a),     0);
      chk({tag, "_b"},     32'(alu_b),     0);
      chk({tag, "_op"},    32'(alu_op),    0);
   endtask

   // stall: cycles of out_ready low on the first term; poke: pulse start while busy.
   task automatic run_seq(input logic [SIZE:0] sf0, input logic [SIZE:0] sf1,
                          input logic [CNT_W-1:0] sn, input int stall, input bit poke,
                          input bit rnd_ready, output int emitted, output int last_term);
      int            q[$];
      int            a, b, s, idx, cyc, stall_left;
      bit            eovf, held, got_done, last_calc, poke_left;
      logic [SIZE:0] hold_data, ea, eb;

      a = int'(sf0); b = int'(sf1); eovf = 1'b0;
      for (int k = 0; k < int'(sn); k++) begin
         s = a + b;
         q.push_back(s % Mod);
         if (s >= Mod) begin
            eovf = 1'b1;
            break;
         end
         a = b;
         b = s % Mod;
      end

      ea = sf0; eb = sf1; idx = 0; cyc = 0; held = 0; got_done = 0; last_calc = 0;
      stall_left = stall; poke_left = poke; last_term = -1; hold_data = '0;

      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      start = 1'b1; f0 = sf0; f1 = sf1; n = sn;
      @(negedge clk);
      // Scramble inputs after accept: n and the seeds must already be latched.
      start = 1'b0; n = CNT_W'($urandom); f0 = (SIZE+1)'($urandom); f1 = (SIZE+1)'($urandom);
      chk("accept_valid", 32'(out_valid), 0);
      chk("accept_busy",  32'(busy),      1);

      while (!got_done && cyc < 200) begin
         start = 1'b0;
         if (done) begin
            got_done = 1'b1;
            chk("done_valid", 32'(out_valid), 0);
            chk("done_terms", 32'(idx), 32'(q.size()));
            chk("done_ovf",   32'(ovf), 32'(eovf));
            if (sn == '0) chk("n0_latency", 32'(cyc), 0);
         end else if (out_valid) begin
            if (held) chk("hold_data", 32'(out_data), 32'(hold_data));
            chk("wait_op", 32'(alu_op), 0);
            chk("wait_a",  32'(alu_a),  32'(eb));
            chk("wait_b",  32'(alu_b),  32'(out_data));
            if (stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end else begin
               out_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            end
            if (poke_left) begin
               start = 1'b1; f0 = (SIZE+1)'($urandom); f1 = (SIZE+1)'($urandom);
               n = CNT_W'($urandom);
               poke_left = 1'b0;
            end
            if (out_ready) begin
               if (idx < q.size()) chk("term", 32'(out_data), 32'(q[idx]));
               else chk("extra_term", 32'(idx), 32'(q.size()));
               last_term = int'(out_data);
               ea = eb; eb = out_data;
               idx++;
               held = 1'b0;
            end else begin
               held = 1'b1;
               hold_data = out_data;
            end
            last_calc = 1'b0;
         end else begin
            chk("calc_once", 32'(last_calc), 0);
            chk("calc_op",   32'(alu_op), 32'(3'b100));
            chk("calc_a",    32'(alu_a),  32'(ea));
            chk("calc_b",    32'(alu_b),  32'(eb));
            last_calc = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      if (!got_done) chk("timeout", 0, 1);
      start = 1'b0;
      chk("post_done",  32'(done), 0);
      chk("post_busy",  32'(busy), 0);
      chk("post_ovf",   32'(ovf),  32'(eovf));
      emitted = idx;
   endtask

   initial begin
      int cnt, last;

      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Classic sequence from 1,1.
      run_seq(6'd1, 6'd1, 4'd5, 0, 1'b0, 1'b0, cnt, last);
      chk("t1_count", 32'(cnt), 5);
      chk("t1_last",  32'(last), 13);
      chk("t1_ovf",   32'(ovf), 0);

      // Zero-length request.
      run_seq(6'd7, 6'd9, 4'd0, 0, 1'b0, 1'b0, cnt, last);
      chk("t2_count", 32'(cnt), 0);

      // Carry terminates early and stays sticky.
      run_seq(6'd21, 6'd34, 4'd3, 0, 1'b0, 1'b0, cnt, last);
      chk("t3_count", 32'(cnt), 2);
      chk("t3_last",  32'(last), 25);
      chk("t3_ovf",   32'(ovf), 1);
      repeat (3) @(negedge clk);
      chk("t3_ovf_sticky", 32'(ovf), 1);

      // Back-pressure on the first term.
      run_seq(6'd1, 6'd2, 4'd3, 3, 1'b0, 1'b0, cnt, last);
      chk("t4_count", 32'(cnt), 3);
      chk("t4_last",  32'(last), 8);
      chk("t4_ovf",   32'(ovf), 0);

      // Start pulsed while busy is ignored.
      run_seq(6'd2, 6'd3, 4'd4, 1, 1'b1, 1'b0, cnt, last);
      chk("t6_count", 32'(cnt), 4);
      chk("t6_last",  32'(last), 21);

      // Asynchronous reset while a term waits in WAIT.
      @(negedge clk);
      start = 1'b1; f0 = 6'd3; f1 = 6'd4; n = 4'd4; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("t5_valid_before", 32'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("t5");
      @(negedge clk);
      rst_n = 1'b1;
      run_seq(6'd5, 6'd8, 4'd3, 0, 1'b0, 1'b1, cnt, last);
      chk("t5_rerun_last", 32'(last), 34);

      for (int i = 0; i < 25; i++) begin
         run_seq((SIZE+1)'($urandom), (SIZE+1)'($urandom), CNT_W'($urandom),
                 int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'b1, cnt, last);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
